// File: rtl/irq_bridge.sv
// irq_bridge: decodes CPU word addresses onto N_DEV device slots plus one
// interrupt controller slot. The controller holds a mask, a per-source
// edge/level mode, a pending register and a highest-pending index.
module irq_bridge #(
  parameter int          N_DEV   = 4,
  parameter int          N_IRQ   = 6,
  parameter int          SLOT_AW = 3,
  parameter logic [31:0] BASE    = 32'h0000_7F00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:2]           PrAddr,
  input  logic [31:0]           PrWD,
  input  logic                  PrWe,
  output logic [31:0]           PrRD,
  output logic [SLOT_AW-1:0]    dev_addr,
  output logic [31:0]           dev_wd,
  output logic [N_DEV-1:0]      dev_we,
  input  logic [32*N_DEV-1:0]   dev_rd,
  input  logic [N_IRQ-1:0]      irq_src,
  output logic [N_IRQ-1:0]      HWInt
);

  // Window arithmetic is done on word addresses; the controller occupies
  // the slot directly after the last device slot.
  localparam logic [29:0] BASE_W   = BASE[31:2];
  localparam logic [29:0] SPAN_W   = 30'((N_DEV + 1) << SLOT_AW);
  localparam logic [29:0] OFF_MASK = 30'((1 << SLOT_AW) - 1);
  localparam logic [29:0] CTRL_IDX = 30'(N_DEV);

  localparam logic [29:0] OFF_IMASK = 30'd0;
  localparam logic [29:0] OFF_IMODE = 30'd1;
  localparam logic [29:0] OFF_IPEND = 30'd2;
  localparam logic [29:0] OFF_IHIGH = 30'd3;

  logic [29:0]      word_off;
  logic [29:0]      slot_idx;
  logic [29:0]      reg_off;
  logic             in_range;
  logic             ctrl_hit;

  logic             wr_imask;
  logic             wr_imode;
  logic             wr_ipend;

  logic [N_IRQ-1:0] imask;
  logic [N_IRQ-1:0] imode;
  logic [N_IRQ-1:0] ipend;
  logic [N_IRQ-1:0] src_q;

  logic [N_IRQ-1:0] imask_next;
  logic [N_IRQ-1:0] imode_next;
  logic [N_IRQ-1:0] ipend_next;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] mode_chg;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pend_masked;
  logic [31:0]      ihigh;

  assign dev_addr = PrAddr[SLOT_AW+1:2];
  assign dev_wd   = PrWD;

  // Address decode: which slot (if any) the current word address falls in.
  always_comb begin
    word_off = PrAddr - BASE_W;
    in_range = (PrAddr >= BASE_W) && (word_off < SPAN_W);
    slot_idx = word_off >> SLOT_AW;
    reg_off  = word_off & OFF_MASK;
    ctrl_hit = in_range && (slot_idx == CTRL_IDX);
    wr_imask = PrWe && ctrl_hit && (reg_off == OFF_IMASK);
    wr_imode = PrWe && ctrl_hit && (reg_off == OFF_IMODE);
    wr_ipend = PrWe && ctrl_hit && (reg_off == OFF_IPEND);
  end

  // One-hot device write enables; unmapped addresses enable nothing.
  always_comb begin
    dev_we = '0;
    for (int k = 0; k < N_DEV; k++) begin
      dev_we[k] = PrWe && in_range && (slot_idx == 30'(k));
    end
  end

  // Highest pending-and-enabled source, reported as index+1 (0 = none).
  always_comb begin
    ihigh       = '0;
    pend_masked = ipend & imask;
    for (int i = 0; i < N_IRQ; i++) begin
      if (pend_masked[i]) ihigh = 32'(i + 1);
    end
  end

  // Read mux: device slice, controller register, or zero on a miss.
  always_comb begin
    PrRD = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (in_range && (slot_idx == 30'(k))) PrRD = dev_rd[32*k +: 32];
    end
    if (ctrl_hit) begin
      case (reg_off)
        OFF_IMASK: PrRD[N_IRQ-1:0] = imask;
        OFF_IMODE: PrRD[N_IRQ-1:0] = imode;
        OFF_IPEND: PrRD[N_IRQ-1:0] = ipend;
        OFF_IHIGH: PrRD = ihigh;
        default:   PrRD = '0;
      endcase
    end
  end

  // Next-state for the controller: mode change clears, edge bits latch
  // rises (a rise beats a same-cycle clear), level bits follow the source.
  always_comb begin
    imask_next = wr_imask ? PrWD[N_IRQ-1:0] : imask;
    imode_next = wr_imode ? PrWD[N_IRQ-1:0] : imode;
    clr        = wr_ipend ? PrWD[N_IRQ-1:0] : '0;
    mode_chg   = wr_imode ? (PrWD[N_IRQ-1:0] ^ imode) : '0;
    rise       = irq_src & ~src_q;
    ipend_next = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (mode_chg[i])        ipend_next[i] = 1'b0;
      else if (imode_next[i]) ipend_next[i] = rise[i] | (ipend[i] & ~clr[i]);
      else                    ipend_next[i] = irq_src[i];
    end
  end

  // Controller state; during reset the source history tracks the inputs so
  // a source held high across reset does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      imask <= '0;
      imode <= '0;
      ipend <= '0;
      HWInt <= '0;
      src_q <= irq_src;
    end else begin
      imask <= imask_next;
      imode <= imode_next;
      ipend <= ipend_next;
      HWInt <= ipend_next & imask_next;
      src_q <= irq_src;
    end
  end

endmodule

// File: tb/tb_irq_bridge.sv
// tb_irq_bridge: directed cycles against irq_bridge with a scoreboard queue;
// a negedge monitor pops expected values and compares them to the outputs.
module tb_irq_bridge;

  localparam int K_RD   = 0;
  localparam int K_HW   = 1;
  localparam int K_WE   = 2;
  localparam int K_ADDR = 3;
  localparam int K_WD   = 4;

  localparam logic [31:0] A_IMASK = 32'h0000_7F80;
  localparam logic [31:0] A_IMODE = 32'h0000_7F84;
  localparam logic [31:0] A_IPEND = 32'h0000_7F88;
  localparam logic [31:0] A_IHIGH = 32'h0000_7F8C;
  localparam logic [31:0] A_OFF4  = 32'h0000_7F90;
  localparam logic [31:0] A_NONE  = 32'h0000_8000;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } sb_t;

  logic         clk;
  logic         rst;
  logic [31:2]  PrAddr;
  logic [31:0]  PrWD;
  logic         PrWe;
  logic [31:0]  PrRD;
  logic [2:0]   dev_addr;
  logic [31:0]  dev_wd;
  logic [3:0]   dev_we;
  logic [127:0] dev_rd;
  logic [5:0]   irq_src;
  logic [5:0]   HWInt;

  sb_t sb_q[$];
  int  vectors;
  int  miscompares;

  irq_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .PrWe     (PrWe),
    .PrRD     (PrRD),
    .dev_addr (dev_addr),
    .dev_wd   (dev_wd),
    .dev_we   (dev_we),
    .dev_rd   (dev_rd),
    .irq_src  (irq_src),
    .HWInt    (HWInt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device read data: slot k returns D0D0_000k.
  always_comb begin
    for (int k = 0; k < 4; k++) dev_rd[32*k +: 32] = 32'hD0D0_0000 | 32'(k);
  end

  // Drive one cycle of inputs, settled just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [31:0] addr,
                               input logic we, input logic [31:0] wd,
                               input logic [5:0] src);
    @(posedge clk);
    #1;
    rst     = r;
    PrAddr  = addr[31:2];
    PrWe    = we;
    PrWD    = wd;
    irq_src = src;
  endtask

  // Queue an expectation for the current cycle's outputs.
  task automatic checkOutput(input int kind, input string name,
                             input logic [31:0] exp);
    sb_t e;
    e.kind = kind;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the outputs mid-cycle.
  always @(negedge clk) begin
    sb_t         e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_RD:    act = PrRD;
        K_HW:    act = 32'(HWInt);
        K_WE:    act = 32'(dev_we);
        K_ADDR:  act = 32'(dev_addr);
        default: act = dev_wd;
      endcase
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Directed sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    PrAddr      = A_NONE[31:2];
    PrWe        = 1'b0;
    PrWD        = '0;
    irq_src     = '0;

    // reset
    applyStimulus(1, A_NONE, 0, 0, 6'h00);
    applyStimulus(0, A_IMASK, 0, 0, 6'h00);
    checkOutput(K_RD, "rst_imask", 32'h0);
    checkOutput(K_HW, "rst_hwint", 32'h0);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "rst_ipend", 32'h0);

    // decode
    applyStimulus(0, 32'h0000_7F20, 1, 32'hA5, 6'h00);
    checkOutput(K_WE,   "slot1_we",   32'h2);
    checkOutput(K_ADDR, "slot1_addr", 32'h0);
    checkOutput(K_WD,   "slot1_wd",   32'hA5);
    checkOutput(K_RD,   "slot1_rd",   32'hD0D0_0001);
    applyStimulus(0, 32'h0000_7F64, 0, 0, 6'h00);
    checkOutput(K_WE,   "slot3_we",   32'h0);
    checkOutput(K_ADDR, "slot3_addr", 32'h1);
    checkOutput(K_RD,   "slot3_rd",   32'hD0D0_0003);
    applyStimulus(0, A_NONE, 1, 32'hFFFF_FFFF, 6'h00);
    checkOutput(K_WE, "unmap_we", 32'h0);
    checkOutput(K_RD, "unmap_rd", 32'h0);
    applyStimulus(0, 32'h0000_7EFC, 1, 32'hFFFF_FFFF, 6'h00);
    checkOutput(K_WE, "below_we", 32'h0);
    checkOutput(K_RD, "below_rd", 32'h0);
    applyStimulus(0, A_OFF4, 1, 32'h3F, 6'h00);
    checkOutput(K_WE, "ctrl_we", 32'h0);
    applyStimulus(0, A_OFF4, 0, 0, 6'h00);
    checkOutput(K_RD, "off4_rd", 32'h0);
    applyStimulus(0, A_IMASK, 0, 0, 6'h00);
    checkOutput(K_RD, "imask_untouched", 32'h0);

    // edge interrupt on bit 0
    applyStimulus(0, A_IMASK, 1, 32'h01, 6'h00);
    applyStimulus(0, A_IMODE, 1, 32'h01, 6'h00);
    applyStimulus(0, A_IMODE, 0, 0, 6'h01);
    checkOutput(K_RD, "imode_rd", 32'h1);
    checkOutput(K_HW, "edge_pre", 32'h0);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "edge_ipend", 32'h1);
    checkOutput(K_HW, "edge_hwint", 32'h1);
    applyStimulus(0, A_IHIGH, 0, 0, 6'h00);
    checkOutput(K_RD, "edge_ihigh", 32'h1);
    checkOutput(K_HW, "edge_hold", 32'h1);
    applyStimulus(0, A_IPEND, 1, 32'h01, 6'h00);
    checkOutput(K_HW, "w1c_same", 32'h1);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "w1c_ipend", 32'h0);
    checkOutput(K_HW, "w1c_hwint", 32'h0);

    // masking keeps pending, unmask re-asserts
    applyStimulus(0, A_NONE, 0, 0, 6'h01);
    applyStimulus(0, A_IMASK, 1, 32'h00, 6'h00);
    checkOutput(K_HW, "premask_hw", 32'h1);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "masked_ipend", 32'h1);
    checkOutput(K_HW, "masked_hw", 32'h0);
    applyStimulus(0, A_IMASK, 1, 32'h01, 6'h00);
    checkOutput(K_HW, "unmask_same", 32'h0);
    applyStimulus(0, A_IPEND, 1, 32'h01, 6'h00);
    checkOutput(K_HW, "unmask_hw", 32'h1);

    // collision: rise and write-1-to-clear together on bit 2
    applyStimulus(0, A_IMODE, 1, 32'h05, 6'h00);
    applyStimulus(0, A_IMASK, 1, 32'h05, 6'h00);
    applyStimulus(0, A_IPEND, 1, 32'h04, 6'h04);
    checkOutput(K_RD, "coll_pre", 32'h0);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "coll_ipend", 32'h4);
    checkOutput(K_HW, "coll_hwint", 32'h4);
    applyStimulus(0, A_IHIGH, 0, 0, 6'h00);
    checkOutput(K_RD, "coll_ihigh", 32'h3);
    applyStimulus(0, A_IPEND, 1, 32'h04, 6'h00);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "coll_clr", 32'h0);
    checkOutput(K_HW, "coll_clr_hw", 32'h0);

    // level interrupts
    applyStimulus(0, A_IMODE, 1, 32'h00, 6'h00);
    applyStimulus(0, A_IMASK, 1, 32'h3F, 6'h00);
    applyStimulus(0, A_NONE, 0, 0, 6'h30);
    applyStimulus(0, A_IPEND, 0, 0, 6'h30);
    checkOutput(K_RD, "lvl_ipend", 32'h30);
    checkOutput(K_HW, "lvl_hwint", 32'h30);
    applyStimulus(0, A_IHIGH, 0, 0, 6'h30);
    checkOutput(K_RD, "lvl_ihigh", 32'h6);
    applyStimulus(0, A_IPEND, 1, 32'h3F, 6'h30);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "lvl_w1c_ign", 32'h30);
    checkOutput(K_HW, "lvl_w1c_hw", 32'h30);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "lvl_release", 32'h0);
    checkOutput(K_HW, "lvl_rel_hw", 32'h0);

    // mode change clears pending bit 3, then it tracks the level
    applyStimulus(0, A_IMODE, 1, 32'h08, 6'h00);
    applyStimulus(0, A_NONE, 0, 0, 6'h08);
    applyStimulus(0, A_IPEND, 0, 0, 6'h08);
    checkOutput(K_RD, "mc_ipend", 32'h8);
    checkOutput(K_HW, "mc_hwint", 32'h8);
    applyStimulus(0, A_IMODE, 1, 32'h00, 6'h08);
    applyStimulus(0, A_IPEND, 0, 0, 6'h08);
    checkOutput(K_RD, "mc_cleared", 32'h0);
    checkOutput(K_HW, "mc_cleared_hw", 32'h0);
    applyStimulus(0, A_IPEND, 0, 0, 6'h00);
    checkOutput(K_RD, "mc_tracks", 32'h8);
    checkOutput(K_HW, "mc_tracks_hw", 32'h8);

    // reset mid-operation with a source held high
    applyStimulus(0, A_IMODE, 1, 32'h02, 6'h00);
    applyStimulus(0, A_NONE, 0, 0, 6'h02);
    applyStimulus(1, A_IPEND, 0, 0, 6'h02);
    checkOutput(K_RD, "prerst_ipend", 32'h2);
    checkOutput(K_HW, "prerst_hw", 32'h2);
    applyStimulus(0, A_IMODE, 1, 32'h02, 6'h02);
    checkOutput(K_RD, "postrst_imode", 32'h0);
    checkOutput(K_HW, "postrst_hw", 32'h0);
    applyStimulus(0, A_IPEND, 0, 0, 6'h02);
    checkOutput(K_RD, "postrst_ipend", 32'h0);
    applyStimulus(0, A_IMASK, 0, 0, 6'h02);
    checkOutput(K_RD, "postrst_imask", 32'h0);
    applyStimulus(0, A_IPEND, 0, 0, 6'h02);
    checkOutput(K_RD, "no_edge_ipend", 32'h0);
    checkOutput(K_HW, "no_edge_hw", 32'h0);

    applyStimulus(0, A_NONE, 0, 0, 6'h00);
    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      $display("[TB] FAIL scoreboard: got %0d left expected 0", sb_q.size());
      miscompares += sb_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/irq_bridge.md
IRQ_BRIDGE -- requirements
Module: irq_bridge

Interface
REQ-001 SHALL have parameter N_DEV, default 4, number of device slots (1..8).
REQ-002 SHALL have parameter N_IRQ, default 6, number of interrupt sources (1..6, maps onto HWInt[7:2] of the CPU).
REQ-003 SHALL have parameter SLOT_AW, default 3, word-address bits per slot (slot = 2^SLOT_AW words).
REQ-004 SHALL have parameter BASE, default 32'h0000_7F00, byte base address of slot 0.
REQ-005 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port PrAddr, input, [31:2], CPU word address.
REQ-008 SHALL have port PrWD, input, 32, CPU write data.
REQ-009 SHALL have port PrWe, input, 1, CPU write strobe.
REQ-010 SHALL have port PrRD, output, 32, read data to CPU.
REQ-011 SHALL have port dev_addr, output, SLOT_AW, word offset within slot (PrAddr[SLOT_AW+1:2]).
REQ-012 SHALL have port dev_wd, output, 32, PrWD passed through.
REQ-013 SHALL have port dev_we, output, N_DEV, one-hot per-slot write enable.
REQ-014 SHALL have port dev_rd, input, 32*N_DEV, slot k read data at bits [32k+31:32k].
REQ-015 SHALL have port irq_src, input, N_IRQ, device interrupt requests, synchronous to clk.
REQ-016 SHALL have port HWInt, output, N_IRQ, registered masked pending interrupts to CPU.

Function
REQ-017 Decode: slot k (0..N_DEV-1) hit SHALL be when PrAddr lies in [BASE + k*4*2^SLOT_AW, next slot); slot N_DEV SHALL be the controller register block.
REQ-018 dev_we[k] SHALL equal PrWe & hit_k, combinational; at most one bit high.
REQ-019 PrRD SHALL be combinational: dev_rd slice of hit slot, controller register on controller hit, 32'h0 on no hit.
REQ-020 Writes to unmapped addresses SHALL have no effect on any state or dev_we.
REQ-021 Controller offsets: 0 IMASK (RW), 1 IMODE (RW, bit=1 rising-edge, 0 level), 2 IPEND (R, write-1-to-clear), 3 IHIGH (R, index+1 of highest-numbered set bit of IPEND&IMASK, 0 if none); other offsets read 0, writes ignored. Bits above N_IRQ-1 read 0.
REQ-022 Edge detection SHALL use a one-register history src_q; rise_i = irq_src[i] & ~src_q[i].
REQ-023 Level-mode bit: IPEND[i] SHALL equal registered irq_src[i] each cycle; write-1-to-clear ignored.
REQ-024 Edge-mode bit: IPEND[i] SHALL set on rise_i, hold until write-1-to-clear; set and clear in same cycle -> set wins.
REQ-025 Writing IMODE SHALL clear IPEND for every bit whose mode value changes, in that write cycle.
REQ-026 HWInt SHALL be registered: HWInt <= IPEND_next & IMASK_next, i.e. 1 cycle after a source rise an unmasked edge interrupt is visible on HWInt; 1 cycle after clear it drops.
REQ-027 Masking SHALL not alter IPEND; unmasking a pending bit asserts HWInt on the next cycle.
REQ-028 Register writes SHALL take effect at the clock edge where PrWe and the controller hit are sampled.

Reset
REQ-029 rst SHALL clear IMASK, IMODE, IPEND and HWInt to 0 at the next rising clk edge.
REQ-030 During rst, src_q SHALL load irq_src, so a source held high through reset produces no edge event after release.
REQ-031 rst asserted mid-operation SHALL discard all pending state; dev_we, dev_wd, dev_addr, PrRD remain combinational through reset.

Verification
REQ-032 Decode: N_DEV=4, write 32'hA5 to BASE+32 (slot 1) -> dev_we=4'b0010, dev_addr=0, dev_wd=32'hA5; read unmapped 32'h0000_8000 -> PrRD=0, dev_we=0.
REQ-033 Edge IRQ: IMASK=6'h01, IMODE=6'h01, pulse irq_src[0] 1 cycle -> IPEND=1, HWInt=6'h01 next cycle, IHIGH=1; write IPEND=1 -> HWInt=0 one cycle later.
REQ-034 Collision: edge on bit 2 in same cycle as write-1-to-clear of bit 2 -> IPEND[2] stays 1.
REQ-035 Level IRQ: IMODE=0, IMASK=6'h3F, hold irq_src=6'h30 -> IPEND=6'h30, IHIGH=6, HWInt=6'h30; release -> all 0 after one cycle; W1C no effect while held.
REQ-036 Reset: irq_src[1] high, IMODE=6'h02, assert rst 1 cycle -> all registers and HWInt 0; irq_src[1] still high -> IPEND stays 0.
REQ-037 Mode change: edge-mode pending bit 3 set, write IMODE bit 3 to 0 -> IPEND[3]=0 that edge, then tracks irq_src[3].
